// File: rtl/trojan_mon_pkg.sv
// Shared definitions for the response MISR monitor: FSM state encoding and
// default MISR polynomial / window length.
package trojan_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } monState_t;

  localparam logic [15:0] DEFAULT_POLY       = 16'h8016;
  localparam int          DEFAULT_WINDOW_LEN = 256;

endpackage

// File: rtl/misr_core.sv
// Single-input MISR register: shifts left, folds the polynomial in when the
// MSB falls out, and injects the new response bit at bit 0.
module misr_core
  import trojan_mon_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] w_next;

  // Bit 0 of the shifted value is always 0, so concatenating din is the XOR.
  assign w_next = {q[WIDTH-2:0], din} ^ (q[WIDTH-1] ? POLY : '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= w_next;
    end
  end

endmodule

// File: rtl/response_misr_monitor.sv
// Compacts WINDOW_LEN valid response bits into a MISR signature and counts
// bit transitions; optional low-activity flag enabled by macro RARE_EVENT_EN.
module response_misr_monitor
  import trojan_mon_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               WINDOW_LEN  = DEFAULT_WINDOW_LEN,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(DEFAULT_POLY),
  parameter int               RARE_THRESH = 2,
  localparam int              CW          = $clog2(WINDOW_LEN + 1)
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic             start,
  input  logic             resp_valid,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    toggle_cnt,
  output logic             rare_flag
);

  monState_t     r_state;
  logic          r_busy;
  logic          r_done;
  logic [CW-1:0] r_sampleCnt;
  logic [CW-1:0] r_toggleCnt;
  logic          r_prevBit;

  logic          w_startAccept;
  logic          w_accept;
  logic          w_lastSample;
  logic          w_finalSample;
  logic [CW-1:0] w_toggleNext;

  assign w_startAccept = start && (r_state != ST_RUN);
  assign w_accept      = (r_state == ST_RUN) && resp_valid;
  assign w_lastSample  = (r_sampleCnt == CW'(WINDOW_LEN - 1));
  assign w_finalSample = w_accept && w_lastSample;
  assign w_toggleNext  = r_toggleCnt + CW'(resp_in ^ r_prevBit);

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk (I1470),
    .clr (I1477 | w_startAccept),
    .en  (w_accept),
    .din (resp_in),
    .q   (signature)
  );

  // Start is only honoured outside RUN; the start-cycle sample is dropped.
  always_ff @(posedge I1470) begin
    if (I1477) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sampleCnt <= '0;
      r_toggleCnt <= '0;
      r_prevBit   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (resp_valid) begin
            r_sampleCnt <= r_sampleCnt + CW'(1);
            r_toggleCnt <= w_toggleNext;
            r_prevBit   <= resp_in;
            if (w_lastSample) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_sampleCnt <= '0;
            r_toggleCnt <= '0;
            r_prevBit   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign toggle_cnt = r_toggleCnt;

`ifdef RARE_EVENT_EN
  localparam logic [31:0] RARE_LIMIT = 32'(RARE_THRESH);

  logic r_rare;

  // Judged on the final transition count as the run enters DONE.
  always_ff @(posedge I1470) begin
    if (I1477 || w_startAccept) begin
      r_rare <= 1'b0;
    end else if (w_finalSample) begin
      r_rare <= (32'(w_toggleNext) < RARE_LIMIT);
    end
  end

  assign rare_flag = r_rare;
`else
  assign rare_flag = 1'b0;
`endif

endmodule
